elevator_ctrl: RTL and testbench

//  Parametrised N-floor elevator controller: latches hall/car requests, runs a

---
 rtl/elevator_ctrl.sv | 122 ++++++++++++
 tb/tb_elevator_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_ctrl.sv
// SCAN-style elevator controller: latches floor requests, sweeps in one direction
// while requests remain beyond the car, times floor-to-floor travel and door dwell.
module elevator_ctrl #(
  parameter int FLOORS     = 4,
  parameter int TRAVEL_CYC = 8,
  parameter int DOOR_CYC   = 4,
  localparam int FLOOR_W   = $clog2(FLOORS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FLOORS-1:0]  req,
  output logic [FLOOR_W-1:0] floor,
  output logic [FLOORS-1:0]  pending,
  output logic               moving_up,
  output logic               moving_down,
  output logic               door_open
);

  localparam int TW = $clog2(TRAVEL_CYC + 1);
  localparam int DW = $clog2(DOOR_CYC + 1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

  state_t             state;
  state_t             nstate;
  logic               dir_up;
  logic               ndir;
  logic [TW-1:0]      tcnt;
  logic [DW-1:0]      dcnt;
  logic [FLOOR_W-1:0] nfloor;
  logic [FLOOR_W-1:0] tf;
  logic [FLOORS-1:0]  comb_req;
  logic [FLOORS-1:0]  clr;
  logic [2:0]         sc_c;
  logic [2:0]         sc_t;
  logic               travel_done;
  logic               door_done;

  // Returns {any above f, any at f, any below f} for request vector v.
  function automatic logic [2:0] scan(input logic [FLOORS-1:0] v,
                                      input logic [FLOOR_W-1:0] f);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (v[i]) begin
        if (FLOOR_W'(i) > f)       r[2] = 1'b1;
        else if (FLOOR_W'(i) == f) r[1] = 1'b1;
        else                       r[0] = 1'b1;
      end
    end
    return r;
  endfunction

  assign comb_req    = pending | req;
  assign tf          = (state == MOVE_DOWN) ? floor - FLOOR_W'(1) : floor + FLOOR_W'(1);
  assign sc_c        = scan(comb_req, floor);
  assign sc_t        = scan(comb_req, tf);
  assign travel_done = (tcnt == TW'(TRAVEL_CYC - 1));
  assign door_done   = (dcnt == DW'(DOOR_CYC - 1));

  always_comb begin
    nstate = state;
    nfloor = floor;
    ndir   = dir_up;
    case (state)
      IDLE: begin
        if (sc_c[1])               nstate = DOOR;
        else if (sc_c[2] && sc_c[0]) nstate = dir_up ? MOVE_UP : MOVE_DOWN;
        else if (sc_c[2])          nstate = MOVE_UP;
        else if (sc_c[0])          nstate = MOVE_DOWN;
      end
      MOVE_UP, MOVE_DOWN: begin
        // Arrival decision is made against the floor being entered, not the one left.
        if (travel_done) begin
          nfloor = tf;
          ndir   = (state == MOVE_UP);
          if (sc_t[1])                                    nstate = DOOR;
          else if ((state == MOVE_UP) ? sc_t[2] : sc_t[0]) nstate = state;
          else                                            nstate = IDLE;
        end
      end
      DOOR: begin
        if (!req[floor] && door_done) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
    clr = (state == DOOR || nstate == DOOR) ?
          ({{(FLOORS-1){1'b0}}, 1'b1} << nfloor) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      floor       <= '0;
      pending     <= '0;
      dir_up      <= 1'b1;
      tcnt        <= '0;
      dcnt        <= '0;
      moving_up   <= 1'b0;
      moving_down <= 1'b0;
      door_open   <= 1'b0;
    end else begin
      state   <= nstate;
      floor   <= nfloor;
      dir_up  <= ndir;
      pending <= (pending | req) & ~clr;
      if ((state == MOVE_UP || state == MOVE_DOWN) && nstate == state && nfloor == floor)
        tcnt <= tcnt + TW'(1);
      else
        tcnt <= '0;
      // A call button for the current floor holds the door by restarting dwell.
      if (state == DOOR && nstate == DOOR && !req[floor])
        dcnt <= dcnt + DW'(1);
      else
        dcnt <= '0;
      moving_up   <= (nstate == MOVE_UP);
      moving_down <= (nstate == MOVE_DOWN);
      door_open   <= (nstate == DOOR);
    end
  end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Scenario bench for elevator_ctrl: expected status-change events (edge index,
// status, floor) are queued as stimulus is driven and matched by a monitor.
module tb_elevator_ctrl;

  localparam logic [2:0] ST_IDLE = 3'b000;
  localparam logic [2:0] ST_UP   = 3'b010;
  localparam logic [2:0] ST_DN   = 3'b001;
  localparam logic [2:0] ST_DOOR = 3'b100;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [1:0] floor;
  logic [3:0] pending;
  logic       moving_up;
  logic       moving_down;
  logic       door_open;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic mon_en = 1'b0;
  logic [4:0] prev_st;
  logic [36:0] exp_q[$];

  elevator_ctrl #(.FLOORS(4), .TRAVEL_CYC(8), .DOOR_CYC(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .floor(floor), .pending(pending),
    .moving_up(moving_up), .moving_down(moving_down), .door_open(door_open)
  );

  // clock / cycle index (value seen at negedge = index of the last rising edge)
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every status change must match the next expected event
  always @(negedge clk) begin
    logic [4:0] cur;
    logic [36:0] e;
    if (mon_en) begin
      cur = {door_open, moving_up, moving_down, floor};
      total++;
      if ($countones({door_open, moving_up, moving_down}) > 1 ||
          (moving_up && floor == 2'd3) || (moving_down && floor == 2'd0)) begin
        bad++;
        $display("FAIL legal_status: got st=%b floor=%0d at edge %0d want at most one legal flag",
                 cur[4:2], floor, cyc);
      end
      if (cur !== prev_st) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL event: got t=%0d st=%b fl=%0d want no change", cyc, cur[4:2], cur[1:0]);
        end else begin
          e = exp_q.pop_front();
          if ({cyc, cur} !== e) begin
            bad++;
            $display("FAIL event: got t=%0d st=%b fl=%0d want t=%0d st=%b fl=%0d",
                     cyc, cur[4:2], cur[1:0], e[36:5], e[4:2], e[1:0]);
          end
        end
        prev_st = cur;
      end
    end
  end

  task automatic push_ev(input int t, input logic [2:0] st, input logic [1:0] fl);
    exp_q.push_back({t, st, fl});
  endtask

  task automatic drain();
    for (int t = 0; t < 400 && exp_q.size() != 0; t++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    push_ev(cyc + 1, ST_IDLE, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    repeat (2) @(negedge clk);
    total++; if (floor !== 2'd0) begin bad++; $display("FAIL rst_floor: got %0d want 0", floor); end
    total++; if (pending !== 4'b0000) begin bad++; $display("FAIL rst_pending: got %b want 0000", pending); end
    total++; if (moving_up !== 1'b0) begin bad++; $display("FAIL rst_up: got %b want 0", moving_up); end
    total++; if (moving_down !== 1'b0) begin bad++; $display("FAIL rst_down: got %b want 0", moving_down); end
    total++; if (door_open !== 1'b0) begin bad++; $display("FAIL rst_door: got %b want 0", door_open); end
    rst_n   = 1'b1;
    prev_st = 5'b0;
    mon_en  = 1'b1;
  endtask

  task automatic test_door_here();
    int k;
    @(negedge clk);
    req = 4'b0001;
    k = cyc + 1;
    push_ev(k, ST_DOOR, 2'd0);
    push_ev(k + 4, ST_IDLE, 2'd0);
    @(negedge clk);
    req = 4'b0000;
    total++; if (pending !== 4'b0000) begin bad++; $display("FAIL here_pending: got %b want 0000", pending); end
    drain();
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL here_timeout: got %0d left want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_up_to_top();
    int k;
    @(negedge clk);
    req = 4'b1000;
    k = cyc + 1;
    push_ev(k, ST_UP, 2'd0);
    push_ev(k + 8, ST_UP, 2'd1);
    push_ev(k + 16, ST_UP, 2'd2);
    push_ev(k + 24, ST_DOOR, 2'd3);
    push_ev(k + 28, ST_IDLE, 2'd3);
    @(negedge clk);
    req = 4'b0000;
    total++; if (pending !== 4'b1000) begin bad++; $display("FAIL top_latched: got %b want 1000", pending); end
    repeat (25) @(negedge clk);
    total++; if (pending !== 4'b0000) begin bad++; $display("FAIL top_served: got %b want 0000", pending); end
    drain();
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL top_timeout: got %0d left want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_return_down();
    int k;
    @(negedge clk);
    req = 4'b0001;
    k = cyc + 1;
    push_ev(k, ST_DN, 2'd3);
    push_ev(k + 8, ST_DN, 2'd2);
    push_ev(k + 16, ST_DN, 2'd1);
    push_ev(k + 24, ST_DOOR, 2'd0);
    push_ev(k + 28, ST_IDLE, 2'd0);
    @(negedge clk);
    req = 4'b0000;
    drain();
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL down_timeout: got %0d left want 0", exp_q.size()); exp_q.delete(); end
    total++; if (pending !== 4'b0000) begin bad++; $display("FAIL down_pending: got %b want 0000", pending); end
  endtask

  task automatic test_reverse_pickup();
    int k;
    @(negedge clk);
    req = 4'b0100;
    k = cyc + 1;
    push_ev(k, ST_UP, 2'd0);
    push_ev(k + 8, ST_UP, 2'd1);
    push_ev(k + 16, ST_DOOR, 2'd2);
    push_ev(k + 20, ST_IDLE, 2'd2);
    push_ev(k + 21, ST_DN, 2'd2);
    push_ev(k + 29, ST_DOOR, 2'd1);
    push_ev(k + 33, ST_IDLE, 2'd1);
    @(negedge clk);
    req = 4'b0000;
    repeat (8) @(negedge clk);
    req = 4'b0010;
    @(negedge clk);
    req = 4'b0000;
    total++; if (pending !== 4'b0110) begin bad++; $display("FAIL rev_both: got %b want 0110", pending); end
    repeat (8) @(negedge clk);
    total++; if (pending !== 4'b0010) begin bad++; $display("FAIL rev_left: got %b want 0010", pending); end
    total++; if (door_open !== 1'b1) begin bad++; $display("FAIL rev_door2: got %b want 1", door_open); end
    drain();
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL rev_timeout: got %0d left want 0", exp_q.size()); exp_q.delete(); end
    total++; if (pending !== 4'b0000) begin bad++; $display("FAIL rev_pending: got %b want 0000", pending); end
  endtask

  task automatic test_dir_last();
    int k;
    int j;
    reset_pulse();
    @(negedge clk);
    req = 4'b0010;
    k = cyc + 1;
    push_ev(k, ST_UP, 2'd0);
    push_ev(k + 8, ST_DOOR, 2'd1);
    push_ev(k + 12, ST_IDLE, 2'd1);
    @(negedge clk);
    req = 4'b0000;
    drain();
    @(negedge clk);
    req = 4'b1001;
    j = cyc + 1;
    push_ev(j, ST_UP, 2'd1);
    push_ev(j + 8, ST_UP, 2'd2);
    push_ev(j + 16, ST_DOOR, 2'd3);
    push_ev(j + 20, ST_IDLE, 2'd3);
    push_ev(j + 21, ST_DN, 2'd3);
    push_ev(j + 29, ST_DN, 2'd2);
    push_ev(j + 37, ST_DN, 2'd1);
    push_ev(j + 45, ST_DOOR, 2'd0);
    push_ev(j + 49, ST_IDLE, 2'd0);
    @(negedge clk);
    req = 4'b0000;
    total++; if (pending !== 4'b1001) begin bad++; $display("FAIL dir_both: got %b want 1001", pending); end
    total++; if (moving_up !== 1'b1) begin bad++; $display("FAIL dir_up_first: got %b want 1", moving_up); end
    drain();
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL dir_timeout: got %0d left want 0", exp_q.size()); exp_q.delete(); end
    total++; if (pending !== 4'b0000) begin bad++; $display("FAIL dir_pending: got %b want 0000", pending); end
  endtask

  task automatic test_door_restart_and_reset();
    int k;
    int m;
    @(negedge clk);
    req = 4'b0100;
    k = cyc + 1;
    push_ev(k, ST_UP, 2'd0);
    push_ev(k + 8, ST_UP, 2'd1);
    push_ev(k + 16, ST_DOOR, 2'd2);
    push_ev(k + 23, ST_IDLE, 2'd2);
    @(negedge clk);
    req = 4'b0000;
    repeat (18) @(negedge clk);
    total++; if (door_open !== 1'b1) begin bad++; $display("FAIL restart_door: got %b want 1", door_open); end
    req = 4'b0100;
    @(negedge clk);
    req = 4'b0000;
    total++; if (pending !== 4'b0000) begin bad++; $display("FAIL restart_nolatch: got %b want 0000", pending); end
    drain();
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL restart_timeout: got %0d left want 0", exp_q.size()); exp_q.delete(); end
    @(negedge clk);
    req = 4'b1000;
    m = cyc + 1;
    push_ev(m, ST_UP, 2'd2);
    push_ev(m + 4, ST_IDLE, 2'd0);
    @(negedge clk);
    req = 4'b0000;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++; if (pending !== 4'b0000) begin bad++; $display("FAIL abort_pending: got %b want 0000", pending); end
    total++; if (floor !== 2'd0) begin bad++; $display("FAIL abort_floor: got %0d want 0", floor); end
    drain();
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL abort_timeout: got %0d left want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_multi_req();
    int k;
    @(negedge clk);
    req = 4'b1110;
    k = cyc + 1;
    push_ev(k, ST_UP, 2'd0);
    push_ev(k + 8, ST_DOOR, 2'd1);
    push_ev(k + 12, ST_IDLE, 2'd1);
    push_ev(k + 13, ST_UP, 2'd1);
    push_ev(k + 21, ST_DOOR, 2'd2);
    push_ev(k + 25, ST_IDLE, 2'd2);
    push_ev(k + 26, ST_UP, 2'd2);
    push_ev(k + 34, ST_DOOR, 2'd3);
    push_ev(k + 38, ST_IDLE, 2'd3);
    @(negedge clk);
    req = 4'b0000;
    total++; if (pending !== 4'b1110) begin bad++; $display("FAIL multi_latch: got %b want 1110", pending); end
    drain();
    total++; if (exp_q.size() !== 0) begin bad++; $display("FAIL multi_timeout: got %0d left want 0", exp_q.size()); exp_q.delete(); end
    total++; if (pending !== 4'b0000) begin bad++; $display("FAIL multi_pending: got %b want 0000", pending); end
  endtask

  initial begin
    test_reset();
    test_door_here();
    test_up_to_top();
    test_return_down();
    test_reverse_pickup();
    test_dir_last();
    test_door_restart_and_reset();
    test_multi_req();
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
